coherence_directory_n: RTL
==========================

// Module: coherence_directory_n
// PURPOSE
//  Parametrised directory controller for an N-cache MSI-style system; replaces the fixed two-cache directory.
//  Holds per-block state (INVALID/SHARED/EXCLUSIVE), a sharer bit-vector, the owner id and the backing data word.
//  Arbitrates cache requests round-robin, issues invalidations and collects acks/dirty data, then grants the block.
//  Processes one transaction at a time.
// PARAMETERS
//  N_CACHES  4  number of cache controllers attached (>=2)
//  ADDR_W    2  block-address width; directory holds 2**ADDR_W blocks
//  DATA_W    8  width of one block data word
//  ID_W      $clog2(N_CACHES)  derived; width of cache/owner id
// PORTS
//  clk          in   1             single clock, rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  req_valid    in   N_CACHES      cache i requests; held until req_ready[i]
//  req_type     in   2*N_CACHES    per cache: 0 RD_SHARED, 1 RD_EXCL, 2 WRITEBACK, 3 reserved
//  req_addr     in   ADDR_W*N      per-cache block address
//  req_data     in   DATA_W*N      per-cache writeback data (type 2 only)
//  req_ready    out  N_CACHES      one-cycle accept pulse to the winner
//  grant_valid  out  N_CACHES      one-cycle completion pulse to the requester
//  grant_excl   out  1             with grant: 1 = exclusive ownership
//  grant_data   out  DATA_W        with grant: current block data
//  inval_valid  out  N_CACHES      invalidate cache i; held until inval_ack[i]
//  inval_addr   out  ADDR_W        block being invalidated
//  inval_ack    in   N_CACHES      cache i has dropped the block
//  inval_dirty  in   N_CACHES      with ack: cache i returns modified data
//  inval_data   in   DATA_W*N      per-cache returned data, valid with ack and dirty
// BEHAVIOUR
//  Reset (async, rst_n=0): every block INVALID, sharers=0, owner=0, data=0; all outputs 0.
//   The rr pointer is N_CACHES-1, so cache 0 wins first. An assertion mid-transaction aborts it; no grant is issued.
//  FSM IDLE -> LOOKUP -> (INVAL ->) GRANT -> IDLE.
//  IDLE: on the edge where any req_valid=1, pick the winner round-robin starting at ptr+1.
//   Latch id/type/addr/data; ptr<=winner; req_ready[winner]=1 for the next cycle only; go to LOOKUP.
//  LOOKUP (one cycle):
//   RD_SHARED, block INVALID/SHARED: sharers|=1<<id, state SHARED -> GRANT.
//   RD_SHARED, EXCLUSIVE, owner!=id: pending={owner} -> INVAL.
//   RD_SHARED, EXCLUSIVE, owner==id: no change -> GRANT (excl=1).
//   RD_EXCL: pending=sharers&~(1<<id), or {owner} if EXCLUSIVE and owner!=id. Pending!=0 -> INVAL, else -> GRANT.
//   WRITEBACK from owner of an EXCLUSIVE block: data<=req_data, state INVALID, sharers 0.
//   WRITEBACK from a non-owner (stale race): data dropped, no change. Both cases -> GRANT, excl=0.
//   Type 3: no change -> GRANT, excl=0.
//  INVAL: inval_valid=pending, inval_addr=latched addr.
//   On an edge with inval_ack[i]&pending[i]: clear pending[i]; if inval_dirty[i], data<=inval_data[i].
//   Acks to non-pending bits are ignored. Several acks in one cycle are all taken; with several dirty acks the lowest index wins.
//   pending==0 -> GRANT. Outputs drop the cycle after each ack.
//  GRANT (one cycle): grant_valid[id]=1, grant_data=block data (including any writeback this transaction).
//   RD_SHARED: state SHARED, sharers=(old sharers minus invalidated) | id.
//   RD_EXCL: state EXCLUSIVE, owner=id, sharers=1<<id, grant_excl=1.
//  Latency: accept pulse at T+1, grant at T+3 without invalidation; INVAL adds (cycles to last ack)+1.
//  Requests arriving during a transaction wait. The winner's req_valid is ignored until the next IDLE.
//  Requests addressing different blocks still serialise.
// TESTING
//  1. Reset, cache0 RD_SHARED addr1 -> req_ready[0] at T+1; grant_valid[0] at T+3, data 0, excl 0; blk1 SHARED {0}.
//  2. Caches 0,1,2 share addr2; cache3 RD_EXCL addr2 -> inval_valid=0b0111.
//     Acks staggered 1/3/5 cycles -> grant[3] the cycle after the last ack, excl 1.
//  3. Cache1 owns addr0; cache2 RD_SHARED -> inval[1]; ack with dirty=1, data 0xA5
//     -> grant[2] data 0xA5; blk0 SHARED {2}.
//  4. All 4 caches assert req_valid together repeatedly -> accepts in order 0,1,2,3,0; no starvation.
//  5. Owner WRITEBACK 0x3C -> grant excl 0, block INVALID. Non-owner WRITEBACK 0xFF -> grant, data stays 0x3C.
//  6. rst_n low while in INVAL -> all outputs 0 immediately; no grant; directory all INVALID after release.

Source files
------------

// File: rtl/coherence_directory_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coherence_directory_n                                                      |
// | MSI directory for N caches: round-robin arbiter, invalidation, grant.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module coherence_directory_n #(
  parameter int N_CACHES = 4,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CACHES-1:0]          req_valid,
  input  logic [2*N_CACHES-1:0]        req_type,
  input  logic [ADDR_W*N_CACHES-1:0]   req_addr,
  input  logic [DATA_W*N_CACHES-1:0]   req_data,
  output logic [N_CACHES-1:0]          req_ready,
  output logic [N_CACHES-1:0]          grant_valid,
  output logic                         grant_excl,
  output logic [DATA_W-1:0]            grant_data,
  output logic [N_CACHES-1:0]          inval_valid,
  output logic [ADDR_W-1:0]            inval_addr,
  input  logic [N_CACHES-1:0]          inval_ack,
  input  logic [N_CACHES-1:0]          inval_dirty,
  input  logic [DATA_W*N_CACHES-1:0]   inval_data
);

  localparam int ID_W = $clog2(N_CACHES);
  localparam int NB   = 2**ADDR_W;

  localparam logic [1:0] BLK_INV = 2'd0;
  localparam logic [1:0] BLK_SHR = 2'd1;
  localparam logic [1:0] BLK_EXC = 2'd2;

  localparam logic [1:0] RQ_RDS = 2'd0;
  localparam logic [1:0] RQ_RDX = 2'd1;
  localparam logic [1:0] RQ_WB  = 2'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_INVAL  = 2'd2;
  localparam logic [1:0] S_GRANT  = 2'd3;

  function automatic logic [N_CACHES-1:0] onehot(input logic [ID_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  logic [1:0]          state, next_state;
  logic [ID_W-1:0]     ptr, cur_id;
  logic [1:0]          cur_type;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_data;
  logic [N_CACHES-1:0] pending, inval_mask;
  logic                keep_excl;

  logic [1:0]          blk_st   [NB];
  logic [N_CACHES-1:0] blk_sh   [NB];
  logic [ID_W-1:0]     blk_own  [NB];
  logic [DATA_W-1:0]   blk_data [NB];

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [N_CACHES-1:0] cur_onehot, lk_pending, ack_hit, dirty_hit;
  logic                lk_keep_excl;
  logic [ID_W-1:0]     dirty_idx;
  logic [1:0]          lk_st;
  logic [N_CACHES-1:0] lk_sh;
  logic [ID_W-1:0]     lk_own;

  assign cur_onehot = onehot(cur_id);
  assign lk_st      = blk_st[cur_addr];
  assign lk_sh      = blk_sh[cur_addr];
  assign lk_own     = blk_own[cur_addr];
  assign ack_hit    = inval_ack & pending;
  assign dirty_hit  = ack_hit & inval_dirty;

  // Scan downward so the candidate nearest ptr+1 is the last (winning) assignment.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = N_CACHES; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % N_CACHES]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(ptr) + k) % N_CACHES);
      end
    end
  end

  always_comb begin
    dirty_idx = '0;
    for (int i = N_CACHES - 1; i >= 0; i--) begin
      if (dirty_hit[i]) dirty_idx = ID_W'(i);
    end
  end

  always_comb begin
    lk_pending   = '0;
    lk_keep_excl = 1'b0;
    case (cur_type)
      RQ_RDS: begin
        if (lk_st == BLK_EXC) begin
          if (lk_own != cur_id) lk_pending = onehot(lk_own);
          else                  lk_keep_excl = 1'b1;
        end
      end
      RQ_RDX: begin
        if (lk_st == BLK_EXC && lk_own != cur_id) lk_pending = onehot(lk_own);
        else                                      lk_pending = lk_sh & ~cur_onehot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (win_found) next_state = S_LOOKUP;
      S_LOOKUP: next_state = (|lk_pending) ? S_INVAL : S_GRANT;
      S_INVAL:  if ((pending & ~ack_hit) == '0) next_state = S_GRANT;
      S_GRANT:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    inval_valid = '0;
    inval_addr  = '0;
    if (state == S_INVAL) begin
      inval_valid = pending;
      inval_addr  = cur_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= ID_W'(N_CACHES - 1);
      cur_id      <= '0;
      cur_type    <= '0;
      cur_addr    <= '0;
      cur_data    <= '0;
      pending     <= '0;
      inval_mask  <= '0;
      keep_excl   <= 1'b0;
      req_ready   <= '0;
      grant_valid <= '0;
      grant_excl  <= 1'b0;
      grant_data  <= '0;
      for (int b = 0; b < NB; b++) begin
        blk_st[b]   <= BLK_INV;
        blk_sh[b]   <= '0;
        blk_own[b]  <= '0;
        blk_data[b] <= '0;
      end
    end else begin
      req_ready   <= '0;
      grant_valid <= '0;
      grant_excl  <= 1'b0;
      grant_data  <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            cur_id    <= win_id;
            ptr       <= win_id;
            cur_type  <= req_type[int'(win_id)*2 +: 2];
            cur_addr  <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
            cur_data  <= req_data[int'(win_id)*DATA_W +: DATA_W];
            req_ready <= onehot(win_id);
          end
        end
        S_LOOKUP: begin
          pending    <= lk_pending;
          inval_mask <= lk_pending;
          keep_excl  <= lk_keep_excl;
          // Only the current owner's writeback is trusted; stale ones are dropped.
          if (cur_type == RQ_WB && lk_st == BLK_EXC && lk_own == cur_id) begin
            blk_data[cur_addr] <= cur_data;
            blk_st[cur_addr]   <= BLK_INV;
            blk_sh[cur_addr]   <= '0;
          end
        end
        S_INVAL: begin
          pending <= pending & ~ack_hit;
          if (|dirty_hit) blk_data[cur_addr] <= inval_data[int'(dirty_idx)*DATA_W +: DATA_W];
        end
        S_GRANT: begin
          grant_valid <= cur_onehot;
          grant_data  <= blk_data[cur_addr];
          grant_excl  <= (cur_type == RQ_RDX) || (cur_type == RQ_RDS && keep_excl);
          if (cur_type == RQ_RDS && !keep_excl) begin
            blk_st[cur_addr] <= BLK_SHR;
            blk_sh[cur_addr] <= (lk_sh & ~inval_mask) | cur_onehot;
          end else if (cur_type == RQ_RDX) begin
            blk_st[cur_addr]  <= BLK_EXC;
            blk_own[cur_addr] <= cur_id;
            blk_sh[cur_addr]  <= cur_onehot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
